// File: rtl/uart_pkg.sv
// Shared types for the UART receive controller: frame config, line FSM
// states and the data-width mask used when storing received bytes.
package uart_pkg;

  typedef enum logic [1:0] {
    DB5 = 2'b00,
    DB6 = 2'b01,
    DB7 = 2'b10,
    DB8 = 2'b11
  } data_bits_e;

  typedef struct packed {
    data_bits_e data_bits;
    logic       stop_bits;    // 0 = one stop bit, 1 = two
    logic       parity_en;
    logic       parity_type;  // 0 = even, 1 = odd
  } uart_cfg_t;

  localparam uart_cfg_t UART_CFG_DEFAULT = '{
    data_bits:   DB8,
    stop_bits:   1'b0,
    parity_en:   1'b0,
    parity_type: 1'b0
  };

  typedef enum logic {
    LINE_IDLE  = 1'b0,
    LINE_FRAME = 1'b1
  } line_state_e;

  // FIFO entry: {parity flag, data byte}
  localparam int FIFO_W = 9;

  // Keeps only the bits that belong to the configured character width.
  function automatic logic [7:0] width_mask(input data_bits_e db);
    logic [7:0] m;
    case (db)
      DB5:     m = 8'h1F;
      DB6:     m = 8'h3F;
      DB7:     m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO. Head entry is visible on rdata whenever the
// FIFO is non-empty; rdata reads zero when empty. A push into a full FIFO
// is accepted only when a pop happens on the same edge.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: applies frame config only between frames,
// buffers received bytes with their parity flag, drives rts_n flow control
// with hysteresis, and keeps parity-error / overflow statistics.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int HI_WM = 6,
  parameter int LO_WM = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_data_bit_num,
  input  logic       cfg_stop_bit_num,
  input  logic       cfg_parity_en,
  input  logic       cfg_parity_type,
  output logic       cfg_ack,
  output logic [1:0] data_bit_num,
  output logic       stop_bit_num,
  output logic       parity_en,
  output logic       parity_type,
  input  logic       rxd,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       parity_error,
  input  logic       rd_en,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_err,
  output logic       rts_n,
  output logic       overflow,
  output logic [7:0] err_cnt,
  input  logic       clear_stats
);

  localparam int CW = $clog2(DEPTH) + 1;

  line_state_e        state_q, state_d;
  logic               apply;
  uart_cfg_t          shadow_q, cfg_q;
  logic               pending_q;

  logic [CW-1:0]      count;
  logic               full, empty;
  logic [FIFO_W-1:0]  fifo_wdata, fifo_rdata;
  logic               drop, err_hit;

  // Line FSM next state; apply only from a quiet idle line so a config
  // change can never land on the edge a new start bit is seen.
  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    case (state_q)
      LINE_IDLE: begin
        if (!rxd)           state_d = LINE_FRAME;
        else if (pending_q) apply   = 1'b1;
      end
      LINE_FRAME: begin
        if (rx_done) state_d = LINE_IDLE;
      end
      default: state_d = LINE_IDLE;
    endcase
  end

  // Line FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= LINE_IDLE;
    else       state_q <= state_d;
  end

  // Shadow capture and apply; a write on the apply edge stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q  <= UART_CFG_DEFAULT;
      cfg_q     <= UART_CFG_DEFAULT;
      pending_q <= 1'b0;
      cfg_ack   <= 1'b0;
    end else begin
      cfg_ack <= apply;
      if (apply) begin
        cfg_q     <= shadow_q;
        pending_q <= 1'b0;
      end
      if (cfg_wr) begin
        shadow_q  <= '{data_bits:   data_bits_e'(cfg_data_bit_num),
                       stop_bits:   cfg_stop_bit_num,
                       parity_en:   cfg_parity_en,
                       parity_type: cfg_parity_type};
        pending_q <= 1'b1;
      end
    end
  end

  assign data_bit_num = cfg_q.data_bits;
  assign stop_bit_num = cfg_q.stop_bits;
  assign parity_en    = cfg_q.parity_en;
  assign parity_type  = cfg_q.parity_type;

  assign err_hit    = rx_done && parity_error && cfg_q.parity_en;
  assign drop       = rx_done && full && !rd_en;
  assign fifo_wdata = {err_hit, rx_data & width_mask(cfg_q.data_bits)};

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_done),
    .pop   (rd_en),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign rd_valid = !empty;
  assign rd_data  = fifo_rdata[7:0];
  assign rd_err   = fifo_rdata[8];

  // Flow control with hysteresis on the registered occupancy.
  always_ff @(posedge clk) begin
    if (reset)                          rts_n <= 1'b0;
    else if (count >= CW'(HI_WM))       rts_n <= 1'b1;
    else if (count <= CW'(LO_WM))       rts_n <= 1'b0;
  end

  // Sticky overflow; clear_stats takes priority over a new drop.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) overflow <= 1'b0;
    else if (drop)            overflow <= 1'b1;
  end

  // Saturating parity-error counter; dropped frames still count.
  always_ff @(posedge clk) begin
    if (reset || clear_stats)              err_cnt <= 8'd0;
    else if (err_hit && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a random
// run compared against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int HI_WM = 6;
  localparam int LO_WM = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_data_bit_num = 2'b00;
  logic       cfg_stop_bit_num = 1'b0;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_type = 1'b0;
  logic       cfg_ack;
  logic [1:0] data_bit_num;
  logic       stop_bit_num, parity_en, parity_type;
  logic       rxd = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       parity_error = 1'b0;
  logic       rd_en = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_err, rts_n, overflow;
  logic [7:0] err_cnt;
  logic       clear_stats = 1'b0;

  int checks = 0;
  int passes = 0;

  // reference model
  logic [8:0] mq[$];
  int         m_err = 0;
  bit         m_ovf = 0;
  bit         m_rts = 0;
  logic [1:0] m_db = 2'b11;
  bit         m_pe = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(DEPTH), .HI_WM(HI_WM), .LO_WM(LO_WM)) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr),
    .cfg_data_bit_num(cfg_data_bit_num), .cfg_stop_bit_num(cfg_stop_bit_num),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_type(cfg_parity_type),
    .cfg_ack(cfg_ack), .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
    .parity_en(parity_en), .parity_type(parity_type), .rxd(rxd),
    .rx_done(rx_done), .rx_data(rx_data), .parity_error(parity_error),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .rts_n(rts_n), .overflow(overflow), .err_cnt(err_cnt), .clear_stats(clear_stats)
  );

  // Advance one clock: update the model from the current inputs, then let
  // the DUT take the edge and settle before anything is sampled.
  task automatic cyc();
    int  prev;
    bit  pop_ok, push_ok, errf;
    prev = mq.size();
    if (reset) begin
      mq.delete(); m_err = 0; m_ovf = 0; m_rts = 0; m_db = 2'b11; m_pe = 0;
    end else begin
      if (prev >= HI_WM)      m_rts = 1;
      else if (prev <= LO_WM) m_rts = 0;
      pop_ok  = rd_en && prev > 0;
      push_ok = rx_done && (prev < DEPTH || rd_en);
      errf    = rx_done && parity_error && m_pe;
      if (pop_ok)  void'(mq.pop_front());
      if (push_ok) mq.push_back({errf, rx_data & 8'((1 << (5 + m_db)) - 1)});
      if (clear_stats) begin
        m_err = 0; m_ovf = 0;
      end else begin
        if (rx_done && !push_ok) m_ovf = 1;
        if (errf && m_err < 255) m_err++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
    checks++;
    if ({data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack, rd_valid, rd_err,
         rd_data, rts_n, overflow, err_cnt} !==
        {2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_values: got db=%b sb=%b pe=%b pt=%b ack=%b v=%b e=%b d=%h rts=%b ovf=%b cnt=%0d",
               data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack, rd_valid, rd_err,
               rd_data, rts_n, overflow, err_cnt);
    else passes++;
  endtask

  task automatic test_cfg_idle();
    cfg_wr = 1'b1; cfg_data_bit_num = 2'b01; cfg_stop_bit_num = 1'b1;
    cfg_parity_en = 1'b1; cfg_parity_type = 1'b1;
    cyc();
    cfg_wr = 1'b0;
    {cfg_data_bit_num, cfg_stop_bit_num, cfg_parity_en, cfg_parity_type} = 5'($urandom);
    checks++;
    if ({data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack} !== 6'b11_000_0)
      $display("FAIL cfg_idle_early: got %b expected 110000",
               {data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack});
    else passes++;
    cyc();
    checks++;
    if ({data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack} !== 6'b01_111_1)
      $display("FAIL cfg_idle_apply: got %b expected 011111",
               {data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack});
    else passes++;
    cyc();
    checks++;
    if ({data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack} !== 6'b01_111_0)
      $display("FAIL cfg_ack_pulse: got %b expected 011110",
               {data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack});
    else passes++;
    m_db = 2'b01; m_pe = 1;
  endtask

  task automatic test_cfg_frame();
    rxd = 1'b0; cyc();
    cfg_wr = 1'b1; cfg_data_bit_num = 2'b00; cfg_stop_bit_num = 1'b0;
    cfg_parity_en = 1'b1; cfg_parity_type = 1'b0; rxd = 1'($urandom);
    cyc();
    cfg_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rxd = 1'($urandom); cyc();
      checks++;
      if ({data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack} !== 6'b01_111_0)
        $display("FAIL cfg_frame_hold%0d: got %b expected 011110", i,
                 {data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack});
      else passes++;
    end
    rx_done = 1'b1; rx_data = 8'($urandom); parity_error = 1'b0; rxd = 1'b0;
    cyc();
    rx_done = 1'b0; rxd = 1'b1;
    checks++;
    if ({data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack} !== 6'b01_111_0)
      $display("FAIL cfg_frame_done_edge: got %b expected 011110",
               {data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack});
    else passes++;
    cyc();
    checks++;
    if ({data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack} !== 6'b00_010_1)
      $display("FAIL cfg_frame_apply: got %b expected 000101",
               {data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack});
    else passes++;
    m_db = 2'b00; m_pe = 1;
    checks++;
    if ({rd_valid, rd_err, rd_data} !== {1'b1, mq[0]})
      $display("FAIL cfg_frame_data: got v=%b e=%b d=%h expected e=%b d=%h",
               rd_valid, rd_err, rd_data, mq[0][8], mq[0][7:0]);
    else passes++;
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
  endtask

  task automatic test_mask5();
    rx_done = 1'b1; rx_data = 8'hFF; parity_error = 1'b0; cyc(); rx_done = 1'b0;
    checks++;
    if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b0, 8'h1F})
      $display("FAIL mask5: got v=%b e=%b d=%h expected v=1 e=0 d=1f", rd_valid, rd_err, rd_data);
    else passes++;
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) $display("FAIL mask5_empty: got rd_valid=%b expected 0", rd_valid);
    else passes++;
  endtask

  task automatic test_parity();
    rx_done = 1'b1; parity_error = 1'b1; rx_data = 8'($urandom); cyc();
    rx_done = 1'b0; parity_error = 1'b0;
    checks++;
    if ({rd_err, err_cnt} !== {1'b1, 8'd1})
      $display("FAIL parity_on: got rd_err=%b err_cnt=%0d expected 1/1", rd_err, err_cnt);
    else passes++;
    cfg_wr = 1'b1; {cfg_data_bit_num, cfg_stop_bit_num, cfg_parity_en, cfg_parity_type} = 5'b11_000;
    cyc(); cfg_wr = 1'b0; cyc();
    m_db = 2'b11; m_pe = 0;
    rx_done = 1'b1; parity_error = 1'b1; rx_data = 8'($urandom); cyc();
    rx_done = 1'b0; parity_error = 1'b0;
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    checks++;
    if ({rd_valid, rd_err, err_cnt} !== {1'b1, 1'b0, 8'd1})
      $display("FAIL parity_off: got v=%b rd_err=%b err_cnt=%0d expected 1/0/1", rd_valid, rd_err, err_cnt);
    else passes++;
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
  endtask

  task automatic test_flow();
    reset = 1'b1; cyc(); reset = 1'b0;
    rx_done = 1'b1;
    for (int i = 0; i < 6; i++) begin rx_data = 8'($urandom); cyc(); end
    rx_done = 1'b0;
    checks++;
    if (rts_n !== 1'b0) $display("FAIL rts_at_6th_push: got %b expected 0", rts_n);
    else passes++;
    cyc();
    checks++;
    if (rts_n !== 1'b1) $display("FAIL rts_high: got %b expected 1", rts_n);
    else passes++;
    rd_en = 1'b1; repeat (4) cyc(); rd_en = 1'b0;
    checks++;
    if ({rts_n, rd_data} !== {1'b1, mq[0][7:0]})
      $display("FAIL rts_hold_at_2: got rts=%b d=%h expected 1/%h", rts_n, rd_data, mq[0][7:0]);
    else passes++;
    cyc();
    checks++;
    if (rts_n !== 1'b0) $display("FAIL rts_low: got %b expected 0", rts_n);
    else passes++;
    rx_done = 1'b1;
    for (int i = 0; i < 7; i++) begin rx_data = 8'($urandom); cyc(); end
    rx_done = 1'b0;
    checks++;
    if (overflow !== 1'b1) $display("FAIL overflow_set: got %b expected 1", overflow);
    else passes++;
    clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
    checks++;
    if (overflow !== 1'b0) $display("FAIL overflow_clear: got %b expected 0", overflow);
    else passes++;
    rx_done = 1'b1; rd_en = 1'b1; rx_data = 8'($urandom); cyc();
    rx_done = 1'b0; rd_en = 1'b0;
    checks++;
    if ({overflow, rd_data} !== {1'b0, mq[0][7:0]})
      $display("FAIL full_push_pop: got ovf=%b d=%h expected 0/%h", overflow, rd_data, mq[0][7:0]);
    else passes++;
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (mq.size() == 0 || {rd_valid, rd_data} !== {1'b1, mq[0][7:0]})
        $display("FAIL drain%0d: got v=%b d=%h model_size=%0d", i, rd_valid, rd_data, mq.size());
      else passes++;
      cyc();
    end
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) $display("FAIL drain_empty: got rd_valid=%b expected 0", rd_valid);
    else passes++;
  endtask

  task automatic test_random();
    logic [4:0] c;
    c = 5'($urandom);
    cfg_wr = 1'b1; {cfg_data_bit_num, cfg_stop_bit_num, cfg_parity_en, cfg_parity_type} = c;
    cyc(); cfg_wr = 1'b0; cyc();
    m_db = c[4:3]; m_pe = c[1];
    for (int i = 0; i < 400; i++) begin
      rx_done      = ($urandom % 100) < 45;
      rd_en        = ($urandom % 100) < 35;
      parity_error = 1'($urandom);
      rx_data      = 8'($urandom);
      clear_stats  = ($urandom % 100) < 3;
      cyc();
      checks++;
      if ({rd_valid, rd_err, rd_data, rts_n, overflow, err_cnt} !==
          {mq.size() != 0, (mq.size() != 0) ? mq[0] : 9'h000, m_rts, m_ovf, 8'(m_err)})
        $display("FAIL random_cyc%0d: got v=%b e=%b d=%h rts=%b ovf=%b cnt=%0d expected size=%0d rts=%b ovf=%b cnt=%0d",
                 i, rd_valid, rd_err, rd_data, rts_n, overflow, err_cnt, mq.size(), m_rts, m_ovf, m_err);
      else passes++;
    end
    rx_done = 1'b0; rd_en = 1'b0; parity_error = 1'b0; clear_stats = 1'b0;
  endtask

  task automatic test_saturation();
    cfg_wr = 1'b1; {cfg_data_bit_num, cfg_stop_bit_num, cfg_parity_en, cfg_parity_type} = 5'b11_010;
    cyc(); cfg_wr = 1'b0; cyc();
    m_db = 2'b11; m_pe = 1;
    clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
    rx_done = 1'b1; parity_error = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 260; i++) begin rx_data = 8'($urandom); cyc(); end
    checks++;
    if (err_cnt !== 8'd255) $display("FAIL err_saturate: got %0d expected 255", err_cnt);
    else passes++;
    clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
    rx_done = 1'b0; parity_error = 1'b0; rd_en = 1'b0;
    checks++;
    if ({err_cnt, overflow} !== {8'd0, 1'b0})
      $display("FAIL clear_wins: got cnt=%0d ovf=%b expected 0/0", err_cnt, overflow);
    else passes++;
  endtask

  task automatic test_reset_mid();
    rxd = 1'b0; cyc();
    cfg_wr = 1'b1; {cfg_data_bit_num, cfg_stop_bit_num, cfg_parity_en, cfg_parity_type} = 5'b00_111;
    rx_done = 1'b1; parity_error = 1'b1; rx_data = 8'($urandom); cyc();
    cfg_wr = 1'b0; rx_done = 1'b0; parity_error = 1'b0; cyc();
    reset = 1'b1; cyc(); reset = 1'b0; rxd = 1'b1;
    checks++;
    if ({data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack, rd_valid, rd_err,
         rd_data, rts_n, overflow, err_cnt} !==
        {2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_mid_values: got db=%b sb=%b pe=%b pt=%b ack=%b v=%b d=%h rts=%b ovf=%b cnt=%0d",
               data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack, rd_valid,
               rd_data, rts_n, overflow, err_cnt);
    else passes++;
    cyc(); cyc();
    checks++;
    if ({data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack} !== 6'b11_000_0)
      $display("FAIL reset_mid_pending: got %b expected 110000",
               {data_bit_num, stop_bit_num, parity_en, parity_type, cfg_ack});
    else passes++;
  endtask

  initial begin
    test_reset();
    test_cfg_idle();
    test_cfg_frame();
    test_mask5();
    test_parity();
    test_flow();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller sitting between the host register side and the UART receiver. It owns the receiver's frame configuration and only applies changes between frames. It buffers completed bytes with their parity status in a small FIFO, and drives `rts_n` hardware flow control from FIFO occupancy with hysteresis. It also keeps a saturating parity-error count and a sticky overflow flag for the host.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 4.
- `HI_WM`, 6: occupancy at or above which `rts_n` deasserts (goes high).
- `LO_WM`, 2: occupancy at or below which `rts_n` reasserts (goes low). `LO_WM` < `HI_WM` ≤ `DEPTH`.

Ports:
- `clk`  in  1  — single clock domain. Reset is synchronous and active-high.
- `reset`  in  1  — synchronous, active-high; clears all state on the next `clk` edge.
- `cfg_wr`  in  1  — one-cycle strobe; captures `cfg_*` into the shadow registers.
- `cfg_data_bit_num`  in  2  — 00=5, 01=6, 10=7, 11=8 data bits.
- `cfg_stop_bit_num`  in  1  — 0=1 stop bit, 1=2 stop bits.
- `cfg_parity_en` / `cfg_parity_type`  in  1 each  — parity enable; 0=even, 1=odd.
- `cfg_ack`  out  1  — one-cycle pulse when the shadow config is applied.
- `data_bit_num`, `stop_bit_num`, `parity_en`, `parity_type`  out  2/1/1/1  — applied config driven to the receiver.
- `rxd`  in  1  — serial line, monitored for start-bit detection only.
- `rx_done`  in  1  — receiver frame-complete strobe.
- `rx_data`  in  8  — received byte, LSB-aligned.
- `parity_error`  in  1  — qualifies `rx_done`.
- `rd_en`  in  1  — host pop.
- `rd_valid`  out  1  — FIFO not empty.
- `rd_data`  out  8  — head entry (show-ahead).
- `rd_err`  out  1  — parity flag stored with the head entry.
- `rts_n`  out  1  — flow control to the remote end; 0 means ready.
- `overflow`  out  1  — sticky; a frame was dropped because the FIFO was full.
- `err_cnt`  out  8  — saturating count of parity-error frames.
- `clear_stats`  in  1  — clears `overflow` and `err_cnt`.

## Operation
- Line FSM, two states:
  - LINE_IDLE → LINE_FRAME when `rxd` is sampled 0.
  - LINE_FRAME → LINE_IDLE on `rx_done`.
- Config capture and apply:
  - `cfg_wr` loads the shadow registers and sets `pending`. A new `cfg_wr` while `pending` overwrites the shadow.
  - Apply happens on any edge where `pending`=1, FSM=LINE_IDLE and `rxd`=1. That edge copies shadow to outputs, clears `pending`, and pulses `cfg_ack`.
  - An apply is never performed on the same edge as the LINE_IDLE→LINE_FRAME transition.
- Push on `rx_done`:
  - The stored byte is `rx_data` with bits at and above the configured width zeroed (5-bit mode keeps [4:0]).
  - The stored flag is `parity_error & parity_en`.
- Full FIFO with `rx_done`:
  - Frame is dropped and `overflow` is set.
  - Exception: if `rd_en` is also asserted, pop and push both occur and there is no overflow.
- `rd_en` while empty is ignored.
- `err_cnt` increments on `rx_done & parity_error & parity_en`, including dropped frames, and saturates at 255.
- `clear_stats` wins over a simultaneous increment or overflow set; the result is 0.

## Timing
- Reset values:
  - Config outputs: `data_bit_num`=11, all other config outputs 0.
  - `cfg_ack`=0, `pending`=0, FSM=LINE_IDLE.
  - FIFO empty: `rd_valid`=0, `rd_data`=0, `rd_err`=0.
  - `rts_n`=0, `overflow`=0, `err_cnt`=0.
- Reset mid-frame or mid-pending discards all of this state.
- Config latency:
  - `cfg_wr` sampled at edge N, line idle: outputs change and `cfg_ack`=1 after edge N+1.
  - Line busy: the apply waits until the first edge after the `rx_done` edge on which `rxd`=1.
- FIFO: `rx_done` at edge N gives `rd_valid`/`rd_data` updated after edge N. `rd_en` at edge N presents the next head after edge N.
- `rts_n` is registered from the post-update occupancy `count`:
  - Goes 1 on the edge after `count` ≥ `HI_WM`.
  - Goes 0 on the edge after `count` ≤ `LO_WM`.
  - Otherwise holds its value.
- All outputs are registered except `rd_valid`, `rd_data` and `rd_err`, which are driven from FIFO state registers.

## Structure
- `uart_pkg`:
  - `data_bits_e` enum (DB5..DB8).
  - `uart_cfg_t` struct covering data bits, stop bits, parity enable and parity type.
  - `UART_CFG_DEFAULT` constant.
  - Width-mask function.
- Sub-module `uart_rx_fifo`: synchronous show-ahead FIFO, 9-bit entries, exposing `count`, `full` and `empty`.
- The FSM, config shadow/apply, flow control and statistics live in `uart_rx_ctrl`.

## Test plan
- Config while idle: `cfg_wr` with 01/1/1/1 → one cycle later outputs read 01/1/1/1 and `cfg_ack` is a single-cycle pulse.
- Config mid-frame: drive `rxd`=0, then `cfg_wr` → outputs unchanged until `rx_done`. Apply occurs on the first following edge with `rxd`=1.
- 5-bit mode with `rx_data`=8'hFF → `rd_data`=8'h1F.
- Parity: `parity_en`=1 and `rx_done` with `parity_error` → `rd_err`=1 and `err_cnt`=1. The same frame with `parity_en`=0 → `rd_err`=0 and no count.
- Flow control with defaults:
  - Push 6 frames → `rts_n`=1 one cycle after the 6th push.
  - Pop to 2 entries → `rts_n`=0.
  - Push to 8, push a 9th → `overflow`=1 and `count` stays 8.
  - Push and pop together at full → no overflow.
- Saturation and clear: 260 parity-error frames → `err_cnt`=255. `clear_stats` together with an error frame → 0. Reset mid-frame → all reset values.
